instr_encoder: RTL

- Encoder for the opcode/control decode path: converts field-level requests (class, rd, rs1, rs2, funct3, imm) into 32-bit RV32I instruction words.
- Streams words with byte addresses to the instruction-memory loader / testbench program builder.
- One output register stage with valid/ready backpressure and a wrapping address counter.
- Supported classes: R_TYPE, LW, SW, BR, I_TYPE, JAL, JALR.

---
 rtl/instr_enc_pkg.sv | 40 ++++
 rtl/instr_field_pack.sv | 83 ++++++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared RV32I opcode constants, request classes and request payload for the instruction encoder.
// Optional immediate range checking is enabled with INSTR_ENC_RANGE_CHK_EN (see instr_field_pack).
package instr_enc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 21;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BR      = 3'd3,
    CLS_I       = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_JALR    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef struct packed {
    instr_class_e       cls;
    logic [2:0]         funct3;
    logic               alt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [IMM_W-1:0]   imm;
  } instr_req_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: request fields to an RV32I word plus a legal flag.
// With INSTR_ENC_RANGE_CHK_EN defined, out-of-range immediates are flagged illegal.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  instr_req_t        req_i,
  output logic [XLEN-1:0]   word_c,
  output logic              legal_c
);

  logic       is_shift;
  logic [6:0] f7_r;
  logic [6:0] f7_sh;
  logic       imm12_ok;
  logic       imm13_ok;
  logic       shamt_ok;
  logic       even_ok;

  assign is_shift = (req_i.funct3 == 3'b001) || (req_i.funct3 == 3'b101);
  assign f7_r     = req_i.alt ? FUNCT7_ALT : 7'b0;
  // Only srai takes the alternate funct7; slli always encodes zero.
  assign f7_sh    = (req_i.alt && (req_i.funct3 == 3'b101)) ? FUNCT7_ALT : 7'b0;

`ifdef INSTR_ENC_RANGE_CHK_EN
  assign imm12_ok = (&req_i.imm[20:11]) || (~|req_i.imm[20:11]);
  assign imm13_ok = (&req_i.imm[20:12]) || (~|req_i.imm[20:12]);
  assign shamt_ok = ~|req_i.imm[20:5];
  assign even_ok  = ~req_i.imm[0];
`else
  logic unused_imm0;
  assign unused_imm0 = req_i.imm[0];
  assign imm12_ok    = 1'b1;
  assign imm13_ok    = 1'b1;
  assign shamt_ok    = 1'b1;
  assign even_ok     = 1'b1;
`endif

  always_comb begin
    word_c  = '0;
    legal_c = 1'b0;
    unique case (req_i.cls)
      CLS_R: begin
        word_c  = {f7_r, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, OPC_R_TYPE};
        legal_c = 1'b1;
      end
      CLS_I: begin
        if (is_shift) begin
          word_c  = {f7_sh, req_i.imm[4:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_I_TYPE};
          legal_c = shamt_ok;
        end else begin
          word_c  = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_I_TYPE};
          legal_c = imm12_ok;
        end
      end
      CLS_LW: begin
        word_c  = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_LW};
        legal_c = imm12_ok;
      end
      CLS_JALR: begin
        word_c  = {req_i.imm[11:0], req_i.rs1, 3'b000, req_i.rd, OPC_JALR};
        legal_c = imm12_ok;
      end
      CLS_SW: begin
        word_c  = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, req_i.imm[4:0], OPC_SW};
        legal_c = imm12_ok;
      end
      CLS_BR: begin
        word_c  = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   req_i.imm[4:1], req_i.imm[11], OPC_BR};
        legal_c = imm13_ok && even_ok;
      end
      CLS_JAL: begin
        word_c  = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11], req_i.imm[19:12], req_i.rd, OPC_JAL};
        legal_c = even_ok;
      end
      default: begin
        word_c  = '0;
        legal_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: one output register with valid/ready, wrapping word address, err pulse.
// Build with INSTR_ENC_RANGE_CHK_EN to drop requests whose immediates do not fit their encoding.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [20:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(IMEM_WORDS);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic              err_q, err_d;

  instr_req_t        req;
  logic [XLEN-1:0]   word_c;
  logic              legal_c;
  logic              accept;
  logic              handshake;

  assign req = '{cls:    instr_class_e'(in_class),
                 funct3: in_funct3,
                 alt:    in_alt,
                 rd:     in_rd,
                 rs1:    in_rs1,
                 rs2:    in_rs2,
                 imm:    in_imm};

  instr_field_pack u_pack (
    .req_i   (req),
    .word_c  (word_c),
    .legal_c (legal_c)
  );

  assign in_ready  = !clear && ((state_q == ST_EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = (state_q == ST_FULL) && out_ready;
  assign idx_inc   = (idx_q == IDX_W'(IMEM_WORDS - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state: clear wins; a handshake advances the index, a legal accept (re)loads the word.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
    end else begin
      err_d = accept && !legal_c;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept && legal_c) begin
            state_d = ST_FULL;
            instr_d = word_c;
          end
        end
        ST_FULL: begin
          if (handshake) begin
            idx_d = idx_inc;
            if (accept && legal_c) begin
              instr_d = word_c;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    addr_d = BASE_ADDR + 32'({idx_d, 2'b00});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

endmodule
